// File: rtl/sramlike_axi_bridge.sv
// Bridges the inst/data sram-like ports onto one single-beat AXI master, one transaction at a time.
// Optional: define SRAMLIKE_AXI_EARLY_WACK_EN to acknowledge writes before the B response.
module sramlike_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;

    logic        req_any;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        wr_blocked;
    logic        wr_both_done;

`ifdef SRAMLIKE_AXI_EARLY_WACK_EN
    logic [1:0]  b_out_q, b_out_d;
    logic        b_en_q;
`endif

    logic unused_axi_resp;
    assign unused_axi_resp = ^{rid, rresp, rlast, bid, bresp};

    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'd0:    strb_of = 4'b0001 << lsb;
            2'd1:    strb_of = lsb[1] ? 4'b1100 : 4'b0011;
            default: strb_of = 4'b1111;
        endcase
    endfunction

    assign arid    = sel_q ? DATA_ID : INST_ID;
    assign awid    = sel_q ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign arlen   = '0;
    assign awlen   = '0;
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign arlock  = '0;
    assign awlock  = '0;
    assign arcache = '0;
    assign awcache = '0;
    assign arprot  = '0;
    assign awprot  = '0;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        wr_both_done = 1'b0;

        req_any   = data_req | inst_req;
        req_wr    = data_req ? data_wr    : inst_wr;
        req_size  = data_req ? data_size  : inst_size;
        req_addr  = data_req ? data_addr  : inst_addr;
        req_wdata = data_req ? data_wdata : inst_wdata;

`ifdef SRAMLIKE_AXI_EARLY_WACK_EN
        bready     = b_en_q;
        wr_blocked = req_wr && (b_out_q >= 2'd2);
`else
        bready     = 1'b0;
        wr_blocked = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // The data_ok cycle is still part of the finished transaction, so hold off accepts.
                if (req_any && !wr_blocked && !inst_ok_q && !data_ok_q) begin
                    data_addr_ok = data_req;
                    inst_addr_ok = !data_req;
                    sel_d        = data_req;
                    size_d       = req_size;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    wstrb_d      = strb_of(req_size, req_addr[1:0]);
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = req_wr ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (sel_q) begin
                        data_rdata_d = rdata;
                        data_ok_d    = 1'b1;
                    end else begin
                        inst_rdata_d = rdata;
                        inst_ok_d    = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            WR_ADDR: begin
                awvalid      = !aw_done_q;
                wvalid       = !w_done_q;
                aw_done_d    = aw_done_q | (awvalid & awready);
                w_done_d     = w_done_q | (wvalid & wready);
                wr_both_done = aw_done_d & w_done_d;
                if (wr_both_done) begin
`ifdef SRAMLIKE_AXI_EARLY_WACK_EN
                    inst_ok_d = !sel_q;
                    data_ok_d = sel_q;
                    state_d   = IDLE;
`else
                    state_d   = WR_RESP;
`endif
                end
            end
`ifndef SRAMLIKE_AXI_EARLY_WACK_EN
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    inst_ok_d = !sel_q;
                    data_ok_d = sel_q;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef SRAMLIKE_AXI_EARLY_WACK_EN
    // Outstanding B count: +1 per completed write, -1 per drained B, saturating at 2.
    always_comb begin
        b_out_d = b_out_q;
        if (wr_both_done && !(bvalid && bready)) begin
            if (b_out_q != 2'd2) begin
                b_out_d = b_out_q + 2'd1;
            end
        end else if (!wr_both_done && bvalid && bready && (b_out_q != 2'd0)) begin
            b_out_d = b_out_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_out_q <= '0;
            b_en_q  <= 1'b0;
        end else begin
            b_out_q <= b_out_d;
            b_en_q  <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
        end
    end

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Scoreboard bench: accepted requests are queued, an AXI slave model answers, a monitor checks every beat and data_ok.
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
    logic [1:0]  inst_size = 0, data_size = 0;
    logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, arcache, awcache;
    logic [31:0] araddr, awaddr, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [3:0]  wstrb;
    logic        arready = 0, rvalid = 0, rlast = 1, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [31:0] rdata = 0;

    sramlike_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte lanes touched by an access: size selects 1/2/4 bytes, aligned down to that size.
    function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
        int nbytes, lo;
        nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        lo     = int'(addr % 4) / nbytes * nbytes;
        return 4'(((1 << nbytes) - 1) << lo);
    endfunction

    typedef struct { bit p; bit wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wd; } req_t;
    typedef struct { bit p; bit wr; logic [31:0] data; int hs; } rsp_t;

    req_t expq[$];
    rsp_t respq[$];
    req_t cur;
    bit   have_cur = 0;
    int   aw_n = 0, w_n = 0, pending = 0, cyc = 0;
    int   ok_cnt[2] = '{0, 0};
    int   last_acc[2] = '{0, 0};
    int   last_ok[2] = '{0, 0};

    task automatic take_cur();
        if (!have_cur) begin
            if (expq.size() == 0) begin
                check("axi_without_request", 32'(expq.size()), 1);
            end else begin
                cur = expq.pop_front();
                have_cur = 1;
                aw_n = 0;
                w_n = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        req_t r;
        rsp_t s;
        cyc++;
        if (rst) begin
            expq.delete();
            respq.delete();
            have_cur = 0;
            pending = 0;
        end else begin
            check("addr_ok_both", 32'(inst_addr_ok & data_addr_ok), 0);
            check("data_ok_both", 32'(inst_data_ok & data_data_ok), 0);
            if (inst_addr_ok || data_addr_ok) begin
                check("accept_while_busy", 32'(pending), 0);
                if (inst_addr_ok) check("inst_over_data_prio", 32'(data_req), 0);
                if (data_addr_ok) r = '{1'b1, data_wr, data_size, data_addr, data_wdata};
                else              r = '{1'b0, inst_wr, inst_size, inst_addr, inst_wdata};
                check("addr_ok_without_req", 32'(r.p ? data_req : inst_req), 1);
                expq.push_back(r);
                pending++;
                last_acc[r.p] = cyc;
            end
            if (have_cur && cur.wr) begin
                check("awvalid_after_hs", 32'(awvalid && aw_n != 0), 0);
                check("wvalid_after_hs", 32'(wvalid && w_n != 0), 0);
            end
            if (arvalid && arready) begin
                take_cur();
                check("ar_for_write", 32'(cur.wr), 0);
                check("araddr", araddr, cur.addr);
                check("arsize", 32'(arsize), 32'({1'b0, cur.size}));
                check("arid", 32'(arid), 32'(cur.p));
                check("arlen_arburst", 32'({arlen, arburst}), 32'({8'd0, 2'b01}));
            end
            if (rvalid && rready && have_cur) begin
                respq.push_back('{cur.p, 1'b0, rdata, cyc});
                have_cur = 0;
            end
            if (awvalid && awready) begin
                take_cur();
                check("aw_for_read", 32'(cur.wr), 1);
                check("awaddr", awaddr, cur.addr);
                check("awsize", 32'(awsize), 32'({1'b0, cur.size}));
                check("awid", 32'(awid), 32'(cur.p));
                check("aw_beats", 32'(aw_n), 0);
                aw_n++;
            end
            if (wvalid && wready) begin
                take_cur();
                check("wdata", wdata, cur.wd);
                check("wstrb", 32'(wstrb), 32'(exp_strb(cur.size, cur.addr)));
                check("wlast", 32'(wlast), 1);
                check("w_beats", 32'(w_n), 0);
                w_n++;
            end
            if (bvalid && bready && have_cur) begin
                check("aw_w_before_b", 32'({aw_n[7:0], w_n[7:0]}), 32'h0101);
                respq.push_back('{cur.p, 1'b1, 32'h0, cyc});
                have_cur = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (p == 1 ? data_data_ok : inst_data_ok) begin
                    ok_cnt[p]++;
                    last_ok[p] = cyc;
                    if (respq.size() == 0) begin
                        check(p == 1 ? "spurious_data_data_ok" : "spurious_inst_data_ok", 32'(respq.size()), 1);
                    end else begin
                        s = respq.pop_front();
                        pending--;
                        check("data_ok_port", 32'(p), 32'(s.p));
                        check("data_ok_delay", 32'(cyc - s.hs), 1);
                        if (!s.wr) check("rdata_out", p == 1 ? data_rdata : inst_rdata, s.data);
                    end
                end
            end
            if (respq.size() > 0 && respq[0].hs < cyc) begin
                check("data_ok_missing", 32'(cyc - respq[0].hs), 1);
                void'(respq.pop_front());
                pending--;
            end
        end
    end

    // AXI slave model: per-channel wait knobs (-1 = random 0..3 wait cycles).
    int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
    int ar_t = 0, r_t = 0, aw_t = 0, w_t = 0, b_t = 0;
    int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0, ab_n = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0, r_abort = 0, use_fix = 0;
    logic [31:0] r_val = 0, rdata_fix = 0;

    function automatic int pick(input int k);
        return (k < 0) ? int'($urandom_range(0, 3)) : k;
    endfunction

    task automatic set_waits(input int a, input int r, input int aw, input int w, input int b);
        ar_w = a; r_w = r; aw_w = aw; w_w = w; b_w = b;
        ar_t = pick(a); r_t = pick(r); aw_t = pick(aw); w_t = pick(w); b_t = pick(b);
        ar_c = 0; aw_c = 0; w_c = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            arready = (ar_c >= ar_t);
            awready = (aw_c >= aw_t) && !aw_got;
            wready  = (w_c >= w_t) && !w_got;
            rvalid  = r_pend && (r_c >= r_t);
            rdata   = rvalid ? r_val : $urandom;
            rid     = 4'($urandom);
            bvalid  = b_pend && (b_c >= b_t);
            @(negedge clk);
            if (rst) begin
                if (r_pend) r_abort = 1;
                b_pend = 0; aw_got = 0; w_got = 0;
            end
            if (r_pend) begin
                if (rvalid && rready) r_pend = 0;
                else if (rvalid && r_abort) begin
                    ab_n++;
                    if (ab_n >= 2) begin r_pend = 0; r_abort = 0; ab_n = 0; end
                end else if (r_c < r_t) r_c++;
            end
            if (arvalid) begin
                if (arready) begin
                    r_pend = 1; r_c = 0; r_t = pick(r_w);
                    r_val = use_fix ? rdata_fix : $urandom;
                    ar_c = 0; ar_t = pick(ar_w);
                end else ar_c++;
            end
            if (b_pend) begin
                if (bvalid && bready) b_pend = 0;
                else if (b_c < b_t) b_c++;
            end
            if (awvalid) begin
                if (awready) begin aw_got = 1; aw_c = 0; aw_t = pick(aw_w); end
                else aw_c++;
            end
            if (wvalid) begin
                if (wready) begin w_got = 1; w_c = 0; w_t = pick(w_w); end
                else w_c++;
            end
            if (aw_got && w_got && !b_pend && !rst) begin
                b_pend = 1; b_c = 0; b_t = pick(b_w); aw_got = 0; w_got = 0;
            end
        end
    end

    task automatic do_req(input bit p, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit wait_done);
        int  base;
        bit  got;
        base = ok_cnt[p];
        got  = 0;
        @(posedge clk); #1;
        if (p) begin data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd; end
        else   begin inst_req = 1; inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd; end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            got = p ? data_addr_ok : inst_addr_ok;
        end
        check(p ? "data_accept_timeout" : "inst_accept_timeout", 32'(got), 1);
        @(posedge clk); #1;
        if (p) data_req = 0; else inst_req = 0;
        if (wait_done && got) begin
            for (int n = 0; n < 400 && ok_cnt[p] == base; n++) @(negedge clk);
            check(p ? "data_done_timeout" : "inst_done_timeout", 32'(ok_cnt[p] != base), 1);
        end
    endtask

    function automatic logic [31:0] ctrl_outs();
        return 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, rready, awvalid, wvalid, bready});
    endfunction

    initial begin
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_outs", ctrl_outs(), 0);
        check("reset_rdata", inst_rdata | data_rdata, 0);
        @(posedge clk); #1 rst = 0;

        set_waits(0, 2, 0, 0, 0);
        use_fix = 1; rdata_fix = 32'h3C1D0000;
        do_req(1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 1'b1);
        check("inst_boot_rdata", inst_rdata, 32'h3C1D0000);
        use_fix = 0;

        set_waits(0, 0, 0, 0, 3);
        do_req(1'b1, 1'b1, 2'd0, 32'h80001003, 32'h000000AB, 1'b1);

        set_waits(0, 0, 0, 0, 0);
        fork
            do_req(1'b0, 1'b0, 2'd2, 32'h00000100, 32'h0, 1'b1);
            do_req(1'b1, 1'b0, 2'd2, 32'h00000200, 32'h0, 1'b1);
        join
        check("inst_after_data_ok", 32'(last_acc[0]), 32'(last_ok[1] + 1));

        set_waits(0, 0, 0, 3, 0);
        do_req(1'b1, 1'b1, 2'd1, 32'h00000402, 32'h1234ABCD, 1'b1);

        set_waits(0, 6, 0, 0, 0);
        do_req(1'b0, 1'b0, 2'd2, 32'h00001000, 32'h0, 1'b0);
        for (int n = 0; n < 50 && !rready; n++) @(negedge clk);
        check("reached_rd_data", 32'(rready), 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("post_reset_ctrl_outs", ctrl_outs(), 0);
        check("post_reset_rdata", inst_rdata | data_rdata, 0);
        base = ok_cnt[0];
        repeat (15) @(negedge clk);
        check("no_ok_after_abort", 32'(ok_cnt[0] - base), 0);

        set_waits(-1, -1, -1, -1, -1);
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_req(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
            end
            for (int j = 0; j < 40; j++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_req(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
            end
        join
        repeat (5) @(negedge clk);
        check("queues_drained", 32'(expq.size() + respq.size() + pending), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

endmodule
